arb_mux_n: RTL and testbench

ARB_MUX_N -- requirements
Module: arb_mux_n

---
 rtl/arb_mux_n.sv | 141 ++++++++++++++
 tb/tb_arb_mux_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_n.sv
// arb_mux_n
//   N-input to one-output multiplexer with a registered output stage.
//   The channel to forward is chosen either by a fixed select (mode = 0)
//   or by round-robin arbitration (mode = 1). Both modes share one
//   "last granted" pointer, so round-robin fairness carries across mode
//   switches. The output register accepts a new word whenever it is
//   empty or is being drained in the same cycle. This gives one word
//   per cycle at full throughput.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select by sel, 1 = round-robin
//   sel        channel select, used when mode = 0
//   in_valid   per-channel valid, bit i = channel i
//   in_data    channel i data at [i*W +: W]
//   in_ready   per-channel ready, at most one bit set
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
//   out_data   registered data word
//   out_ch     channel that supplied out_data
module arb_mux_n #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch
);

    // Fixed select. The result is {found, index}. A select that points
    // past the last channel never grants. The shift already yields 0 in
    // that case, but the range test makes the intent explicit.
    function automatic logic [SW:0] pick_fixed(input logic [N-1:0]  valid,
                                               input logic [SW-1:0] s);
        logic [N-1:0] shifted;
        logic         found;
        shifted = valid >> s;
        found   = (int'(s) < N) && shifted[0];
        return {found, s};
    endfunction

    // Round-robin pick. The result is {found, index}. The search starts
    // one past the last granted channel and wraps modulo N. The channel
    // that was granted last is therefore examined last.
    function automatic logic [SW:0] pick_rr(input logic [N-1:0]  valid,
                                            input logic [SW-1:0] last);
        logic          found;
        logic [SW-1:0] idx;
        int            c;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!found && valid[c[SW-1:0]]) begin
                found = 1'b1;
                idx   = c[SW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Stage p0: combinational grant decision from current inputs and ptr
    logic [SW-1:0] ptr;
    logic          vld_p1;
    logic [W-1:0]  data_p1;
    logic [SW-1:0] ch_p1;

    logic [SW:0]   pick_p0;
    logic          has_grant_p0;
    logic [SW-1:0] grant_p0;
    logic          load_p0;
    logic          xfer_p0;
    logic [W-1:0]  grant_data_p0;

    always_comb begin
        if (mode) begin
            pick_p0 = pick_rr(in_valid, ptr);
        end else begin
            pick_p0 = pick_fixed(in_valid, sel);
        end
    end

    assign has_grant_p0 = pick_p0[SW];
    assign grant_p0     = pick_p0[SW-1:0];

    // The output register can take a word when it is empty or draining.
    assign load_p0 = !vld_p1 || out_ready;

    // The granted channel is valid by construction, so a channel
    // transfer happens exactly when a grant exists and load is high.
    assign xfer_p0 = has_grant_p0 && load_p0;

    // rst_n gates ready so that no handshake is offered while reset is
    // held. Without this gate, an empty output register would otherwise
    // raise ready.
    assign in_ready = (rst_n && xfer_p0) ? (N'(1) << grant_p0) : '0;

    always_comb begin
        grant_data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_p0 == SW'(i)) begin
                grant_data_p0 = in_data[i*W +: W];
            end
        end
    end

    // Stage p1: output register and last-grant pointer
    // ptr resets to N-1, so the first round-robin search starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= SW'(N - 1);
        end else begin
            if (xfer_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= grant_data_p0;
                ch_p1   <= grant_p0;
                ptr     <= grant_p0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
module tb_arb_mux_n;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;

    always #5 clk = ~clk;

    arb_mux_n #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the output register should hold and who was granted last
    int           m_ptr;
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_ch;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = N - 1;
        m_vld  = 1'b0;
        m_data = '0;
        m_ch   = 0;
    endtask

    task automatic set_ramp_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i * 'h11);
    endtask

    // Called at a falling edge with inputs already driven. The task checks
    // the combinational and registered outputs against the model, lets one
    // rising edge pass, advances the model, and returns at the next falling edge.
    task automatic cycle();
        bit             has;
        int             g;
        int             c;
        bit             ld;
        logic [N-1:0]   one;
        logic [N-1:0]   exp_rdy;
        logic [N*W-1:0] tmp;
        #1;
        one = 1;
        has = 0;
        g   = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && ((in_valid >> sel) & 1) != 0) begin
                has = 1;
                g   = int'(sel);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!has && ((in_valid >> c) & 1) != 0) begin
                    has = 1;
                    g   = c;
                end
            end
        end
        ld      = !m_vld || out_ready;
        exp_rdy = (has && ld) ? (one << g) : '0;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, m_data);
        chk("out_ch", out_ch, m_ch);
        @(posedge clk);
        if (has && ld) begin
            tmp    = in_data >> (g * W);
            m_vld  = 1;
            m_data = tmp[W-1:0];
            m_ch   = g;
            m_ptr  = g;
        end else if (out_ready) begin
            m_vld = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int seq_rr2[4] = '{2, 5, 2, 5};

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        set_ramp_data();
        model_reset();

        // Reset state, before any clock edge
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed select stepped 0..7
        mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            cycle();
            chk("fix_data", out_data, s * 'h11);
            chk("fix_ch", out_ch, s);
        end

        // Round-robin, all valid: 0..7,0,1 with no bubble
        mode = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("rr_all_ch", out_ch, k % N);
            chk("rr_all_vld", out_valid, 1);
        end

        // Round-robin after reset with only channels 2 and 5 valid
        do_reset();
        in_valid = 8'h24;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_two_ch", out_ch, seq_rr2[k]);
        end

        // Backpressure while holding 0x33
        mode     = 1'b0;
        in_valid = '1;
        sel      = 3'd3;
        cycle();
        chk("bp_load", out_data, 'h33);
        out_ready = 1'b0;
        sel       = 3'd4;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_hold", out_data, 'h33);
            chk("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next", out_data, 'h44);

        // Fixed select pointing at an idle channel
        sel      = 3'd3;
        in_valid = 8'hF7;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("idle_vld", out_valid, 0);
            chk("idle_rdy", in_ready, 0);
        end

        // Reset asserted between edges while holding a word
        mode     = 1'b1;
        in_valid = '1;
        cycle();
        chk("pre_rst_vld", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_rdy", in_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_ch", out_ch, 0);
        chk("post_rst_vld", out_valid, 1);

        // Randomized traffic with mode switching and backpressure
        for (int it = 0; it < 500; it++) begin
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
